move_scanner: RTL and testbench

- Produces the player's move (`jogadaLinha`, `jogadaColuna`, `jogou`) consumed by the chess-lab datapath's move registers and move edge detector.
- Scans an 8x8 board of square sensors (reed switches or keys) wired as a row/column matrix.
- Debounces whole-board frames and reports each newly occupied or pressed square as a 0-based row/column pair with a one-cycle `jogou` pulse.
- Sits between the board I/O pins and the datapath, replacing manual switch inputs.

---
 rtl/move_scanner.sv | 143 ++++++++++++++
 tb/tb_move_scanner.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/move_scanner.sv
// 8x8 sensor-matrix scanner: drives one row at a time, debounces whole-board
// frames and reports each newly closed square as a one-cycle move pulse.
module move_scanner #(
    parameter int unsigned SETTLE   = 4,
    parameter int unsigned DEBOUNCE = 3,
    parameter int unsigned CW       = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilita,
    input  logic [7:0] colunas_in,
    output logic [7:0] linhas_out,
    output logic [3:0] jogadaLinha,
    output logic [3:0] jogadaColuna,
    output logic       jogou,
    output logic       multiplo,
    output logic [2:0] db_linha_varrida
);

    localparam int unsigned SW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [SW-1:0] DB_MAX      = SW'(DEBOUNCE);

    logic [7:0]    r_sync1;
    logic [7:0]    r_sync2;
    logic [CW-1:0] r_settle;
    logic [2:0]    r_row;
    logic [7:0]    r_linhas;
    logic [55:0]   r_frame;
    logic [63:0]   r_prev;
    logic [SW-1:0] r_stable;
    logic [63:0]   r_board;
    logic [2:0]    r_lin;
    logic [2:0]    r_col;
    logic          r_jogou;
    logic          r_mult;

    logic          w_row_end;
    logic          w_frame_end;
    logic [63:0]   w_full;
    logic [SW-1:0] w_stable_next;
    logic          w_accept;
    logic [63:0]   w_novos;
    logic [5:0]    w_k;
    logic          w_found;
    logic          w_multi;
    logic          w_report;
    logic [63:0]   w_board_next;

    assign w_row_end   = (r_settle == SETTLE_LAST);
    assign w_frame_end = w_row_end && (r_row == 3'd7);
    // Rows 0..6 come from the buffer; row 7 is the sample taken this cycle.
    assign w_full      = {r_sync2, r_frame};
    assign w_novos     = w_full & ~r_board;
    assign w_found     = |w_novos;
    assign w_multi     = |(w_novos & (w_novos - 64'd1));

    // Frame-end debounce and acceptance decision.
    always_comb begin
        w_stable_next = SW'(1);
        w_accept      = 1'b0;
        w_report      = 1'b0;
        w_board_next  = r_board;
        w_k           = 6'd0;
        for (int i = 63; i >= 0; i--) begin
            if (w_novos[i]) begin
                w_k = 6'(i);
            end
        end
        if (w_full == r_prev) begin
            w_stable_next = (r_stable == DB_MAX) ? r_stable : SW'(r_stable + 1'b1);
        end
        if (w_frame_end && (w_stable_next == DB_MAX)) begin
            w_accept = 1'b1;
        end
        if (w_accept) begin
            if (habilita) begin
                // Releases vanish silently; only the lowest new square is latched.
                w_board_next = r_board & w_full;
                if (w_found) begin
                    w_board_next = w_board_next | (64'd1 << w_k);
                    w_report     = 1'b1;
                end
            end else begin
                w_board_next = w_full;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1  <= 8'd0;
            r_sync2  <= 8'd0;
            r_settle <= '0;
            r_row    <= 3'd0;
            r_linhas <= 8'b0000_0001;
            r_frame  <= 56'd0;
            r_prev   <= 64'd0;
            r_stable <= '0;
            r_board  <= 64'd0;
            r_lin    <= 3'd0;
            r_col    <= 3'd0;
            r_jogou  <= 1'b0;
            r_mult   <= 1'b0;
        end else begin
            r_sync1 <= colunas_in;
            r_sync2 <= r_sync1;
            r_jogou <= 1'b0;
            r_mult  <= 1'b0;
            if (w_row_end) begin
                r_settle <= '0;
                r_row    <= r_row + 3'd1;
                r_linhas <= {r_linhas[6:0], r_linhas[7]};
                for (int r = 0; r < 7; r++) begin
                    if (r_row == 3'(r)) begin
                        r_frame[8*r +: 8] <= r_sync2;
                    end
                end
            end else begin
                r_settle <= r_settle + CW'(1);
            end
            if (w_frame_end) begin
                r_prev   <= w_full;
                r_stable <= w_stable_next;
                r_board  <= w_board_next;
            end
            if (w_report) begin
                r_lin   <= w_k[5:3];
                r_col   <= w_k[2:0];
                r_jogou <= 1'b1;
                r_mult  <= w_multi;
            end
        end
    end

    assign linhas_out       = r_linhas;
    assign db_linha_varrida = r_row;
    assign jogadaLinha      = {1'b0, r_lin};
    assign jogadaColuna     = {1'b0, r_col};
    assign jogou            = r_jogou;
    assign multiplo         = r_mult;

endmodule

// File: tb/tb_move_scanner.sv
// Bench for move_scanner: a frame-level board model predicts every output
// each cycle while directed press patterns are applied one frame at a time.
module tb_move_scanner;

    localparam int FRAME = 32;
    localparam int DEB   = 3;

    logic       clock;
    logic       reset;
    logic       habilita;
    logic [7:0] colunas_in;
    logic [7:0] linhas_out;
    logic [3:0] jogadaLinha;
    logic [3:0] jogadaColuna;
    logic       jogou;
    logic       multiplo;
    logic [2:0] db_linha_varrida;

    logic [63:0] sw = 64'd0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int base = 0;
    bit chk_en = 0;
    bit post_rst_chk = 0;

    logic [63:0] m_prev = 64'd0;
    logic [63:0] m_board = 64'd0;
    int m_stable = 0;
    int exp_pulse_cyc = -1;
    int exp_lin = 0;
    int exp_col = 0;
    bit exp_mult = 0;

    int pulses = 0;
    int mult_pulses = 0;
    int last_lin = 0;
    int last_col = 0;

    move_scanner #(.SETTLE(4), .DEBOUNCE(3), .CW(8)) dut (
        .clock            (clock),
        .reset            (reset),
        .habilita         (habilita),
        .colunas_in       (colunas_in),
        .linhas_out       (linhas_out),
        .jogadaLinha      (jogadaLinha),
        .jogadaColuna     (jogadaColuna),
        .jogou            (jogou),
        .multiplo         (multiplo),
        .db_linha_varrida (db_linha_varrida)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Switch matrix: a closed square connects its driven row to its column.
    function automatic logic [7:0] cols_of(input logic [7:0] rows, input logic [63:0] s);
        logic [7:0] c;
        c = 8'd0;
        for (int r = 0; r < 8; r++) begin
            if (rows[r]) c = c | s[8*r +: 8];
        end
        return c;
    endfunction
    assign colunas_in = cols_of(linhas_out, sw);

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            if (n_bad <= 100)
                $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] sq(input int r, input int c);
        logic [63:0] v;
        v = 64'd0;
        v[8*r + c] = 1'b1;
        return v;
    endfunction

    // Frame-level model: one whole-board snapshot per frame.
    task automatic model_frame(input logic [63:0] full, input bit hab);
        logic [63:0] novos;
        int k;
        if (full == m_prev) m_stable = (m_stable < DEB) ? m_stable + 1 : DEB;
        else m_stable = 1;
        m_prev = full;
        if (m_stable == DEB) begin
            novos = full & ~m_board;
            if (hab) begin
                m_board = m_board & full;
                if (novos != 64'd0) begin
                    k = 0;
                    while (!novos[k]) k++;
                    m_board[k] = 1'b1;
                    exp_pulse_cyc = cyc;
                    exp_lin = k / 8;
                    exp_col = k % 8;
                    exp_mult = ($countones(novos) > 1);
                end
            end else begin
                m_board = full;
            end
        end
    endtask

    task automatic run_frame(input logic [63:0] pat, input bit hab);
        sw = pat;
        habilita = hab;
        repeat (FRAME) @(posedge clock);
        #1;
        model_frame(pat, hab);
    endtask

    task automatic run_frames(input logic [63:0] pat, input bit hab, input int n);
        for (int i = 0; i < n; i++) run_frame(pat, hab);
    endtask

    task automatic do_reset(input int offset);
        repeat (offset) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        base = cyc;
        m_prev = 64'd0;
        m_board = 64'd0;
        m_stable = 0;
        exp_lin = 0;
        exp_col = 0;
        exp_pulse_cyc = -1;
        post_rst_chk = 1;
    endtask

    always @(negedge clock) begin : cmp
        int k;
        int r;
        bit p;
        if (chk_en) begin
            k = cyc - base;
            r = (k / 4) % 8;
            p = (cyc == exp_pulse_cyc);
            check("linhas_out", int'(linhas_out), 1 << r);
            check("db_linha_varrida", int'(db_linha_varrida), r);
            check("jogou", int'(jogou), int'(p));
            check("multiplo", int'(multiplo), int'(p && exp_mult));
            check("jogadaLinha", int'(jogadaLinha), exp_lin);
            check("jogadaColuna", int'(jogadaColuna), exp_col);
            if (post_rst_chk) begin
                post_rst_chk = 0;
                check("rst_jogou", int'(jogou), 0);
                check("rst_linhas", int'(linhas_out), 1);
                check("rst_coord", int'({jogadaLinha, jogadaColuna}), 0);
            end
            if (jogou) begin
                pulses++;
                if (multiplo) mult_pulses++;
                last_lin = int'(jogadaLinha);
                last_col = int'(jogadaColuna);
            end
        end
    end

    initial begin : stim
        int p0;
        int m0;
        reset = 1'b1;
        habilita = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        base = cyc;
        chk_en = 1;
        post_rst_chk = 1;

        // 1: empty board, no moves
        p0 = pulses;
        run_frames(64'd0, 1'b1, 10);
        check("t1_pulses", pulses - p0, 0);

        // 2: single held square
        p0 = pulses;
        m0 = mult_pulses;
        run_frames(sq(2, 5), 1'b1, 5);
        check("t2_pulses", pulses - p0, 1);
        check("t2_lin", last_lin, 2);
        check("t2_col", last_col, 5);
        check("t2_mult", mult_pulses - m0, 0);
        run_frames(64'd0, 1'b1, 3);

        // 3: two squares in one frame, reported lowest index first
        p0 = pulses;
        m0 = mult_pulses;
        run_frames(sq(2, 5) | sq(0, 7), 1'b1, 5);
        check("t3_pulses", pulses - p0, 2);
        check("t3_mult", mult_pulses - m0, 1);
        check("t3_lin", last_lin, 2);
        check("t3_col", last_col, 5);
        run_frames(64'd0, 1'b1, 3);

        // 4: bouncing press
        p0 = pulses;
        run_frame(sq(4, 1), 1'b1);
        run_frame(64'd0, 1'b1);
        run_frame(sq(4, 1), 1'b1);
        run_frame(64'd0, 1'b1);
        check("t4_bounce_pulses", pulses - p0, 0);
        run_frames(sq(4, 1), 1'b1, 4);
        check("t4_pulses", pulses - p0, 1);
        check("t4_lin", last_lin, 4);
        check("t4_col", last_col, 1);
        run_frames(64'd0, 1'b1, 3);

        // 5: suppressed press is absorbed, re-press is reported
        p0 = pulses;
        run_frames(sq(6, 6), 1'b0, 4);
        run_frames(sq(6, 6), 1'b1, 3);
        check("t5_suppressed", pulses - p0, 0);
        run_frames(64'd0, 1'b1, 3);
        run_frames(sq(6, 6), 1'b1, 4);
        check("t5_pulses", pulses - p0, 1);
        check("t5_lin", last_lin, 6);
        check("t5_col", last_col, 6);

        // 6: reset during the pulse, then in the middle of row 3
        p0 = pulses;
        run_frames(sq(3, 3), 1'b1, 3);
        do_reset(0);
        run_frames(sq(3, 3), 1'b1, 4);
        check("t6_pulses_a", pulses - p0, 2);
        do_reset(14);
        run_frames(sq(3, 3), 1'b1, 4);
        check("t6_pulses_b", pulses - p0, 3);
        check("t6_lin", last_lin, 3);
        check("t6_col", last_col, 3);

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
